// File: rtl/interrupt_controller_pkg.sv
// Shared constants and types for the interrupt controller slice.
// Register addresses, CTRL bit positions and IRQ index width live here.
package interrupt_controller_pkg;

  localparam int IRQ_ID_W = 4;
  localparam int MAX_IRQ  = 16;
  localparam int CFG_W    = 16;

  localparam logic [1:0] REG_ENABLE  = 2'd0;
  localparam logic [1:0] REG_PENDING = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_CAUSE   = 2'd3;

  localparam int CTRL_GIE    = 0;
  localparam int CTRL_INSERV = 1;

  // Handler-side state bundle; kept as one struct so checkers can bind to it.
  typedef struct packed {
    logic                gie;
    logic                in_service;
    logic [IRQ_ID_W-1:0] irq_id;
  } ctrl_state_t;

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// Fixed-priority encoder: reports whether any request is set and the
// lowest set index.
module irq_priority_encoder
  import interrupt_controller_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0]  req,
  output logic                valid,
  output logic [IRQ_ID_W-1:0] index
);

  // Scan from the top down so the lowest set index is the last to write.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = IRQ_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-detecting, fixed-priority interrupt controller feeding the PC's intr
// request, with a small config/status register file on the CPU data bus.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic                absJmp,
  input  logic                relJmp,
  input  logic                reti,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_addr,
  input  logic [CFG_W-1:0]    cfg_wdata,
  output logic [CFG_W-1:0]    cfg_rdata,
  output logic                intr,
  output logic                in_service,
  output logic [IRQ_ID_W-1:0] irq_id
);

  logic [NUM_IRQ-1:0]  enable_q;
  logic [NUM_IRQ-1:0]  pending_q;
  logic [NUM_IRQ-1:0]  pending_d;
  logic [NUM_IRQ-1:0]  irq_prev_q;
  logic [NUM_IRQ-1:0]  edge_det;
  logic [NUM_IRQ-1:0]  req;
  ctrl_state_t         st_q;

  logic                sel_valid;
  logic [IRQ_ID_W-1:0] sel_idx;
  logic                take;
  logic                enable_we;
  logic                pending_we;
  logic                ctrl_we;
  logic [CFG_W-1:0]    enable_ext;
  logic [CFG_W-1:0]    pending_ext;
  logic                unused_wdata;

  assign unused_wdata = ^cfg_wdata;

  assign edge_det = irq_in & ~irq_prev_q;
  assign req      = pending_q & enable_q;

  irq_priority_encoder #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio (
    .req   (req),
    .valid (sel_valid),
    .index (sel_idx)
  );

  // intr/PC contract: intr is a request the PC always accepts in the cycle it
  // is high; the controller withholds it whenever the PC is applying a jump or
  // a reti, since those would overwrite the return address being saved.
  assign take = st_q.gie & ~st_q.in_service & sel_valid
              & ~absJmp & ~relJmp & ~reti;
  assign intr = take;

  assign enable_we  = cfg_we && (cfg_addr == REG_ENABLE);
  assign pending_we = cfg_we && (cfg_addr == REG_PENDING);
  assign ctrl_we    = cfg_we && (cfg_addr == REG_CTRL);

  // Clears (take, W1C) are applied first so a same-cycle new edge wins.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (take && (sel_idx == IRQ_ID_W'(i))) begin
        pending_d[i] = 1'b0;
      end
    end
    if (pending_we) begin
      pending_d = pending_d & ~cfg_wdata[NUM_IRQ-1:0];
    end
    pending_d = pending_d | edge_det;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q   <= '0;
      pending_q  <= '0;
      irq_prev_q <= '0;
      st_q       <= '0;
    end else begin
      irq_prev_q <= irq_in;
      pending_q  <= pending_d;
      if (enable_we) begin
        enable_q <= cfg_wdata[NUM_IRQ-1:0];
      end
      if (ctrl_we) begin
        st_q.gie <= cfg_wdata[CTRL_GIE];
      end
      if (take) begin
        st_q.in_service <= 1'b1;
        st_q.irq_id     <= sel_idx;
      end else if (reti) begin
        st_q.in_service <= 1'b0;
      end
    end
  end

  assign in_service = st_q.in_service;
  assign irq_id     = st_q.irq_id;

  always_comb begin
    enable_ext                = '0;
    enable_ext[NUM_IRQ-1:0]   = enable_q;
    pending_ext               = '0;
    pending_ext[NUM_IRQ-1:0]  = pending_q;
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      REG_ENABLE:  cfg_rdata = enable_ext;
      REG_PENDING: cfg_rdata = pending_ext;
      REG_CTRL: begin
        cfg_rdata[CTRL_GIE]    = st_q.gie;
        cfg_rdata[CTRL_INSERV] = st_q.in_service;
      end
      default:     cfg_rdata = {{(CFG_W-IRQ_ID_W){1'b0}}, st_q.irq_id};
    endcase
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: hand-derived vector table,
// directed corner sequences and randomized traffic against a reference model.
module tb_interrupt_controller;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_in;
  logic          absJmp, relJmp, reti, cfg_we;
  logic [1:0]    cfg_addr;
  logic [15:0]   cfg_wdata;
  logic [15:0]   cfg_rdata;
  logic          intr, in_service;
  logic [3:0]    irq_id;

  int checks = 0;
  int failures = 0;

  interrupt_controller #(.NUM_IRQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .absJmp     (absJmp),
    .relJmp     (relJmp),
    .reti       (reti),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .intr       (intr),
    .in_service (in_service),
    .irq_id     (irq_id)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (rule level) ----------------
  bit       m_en   [N];
  bit       m_pend [N];
  bit       m_prev [N];
  bit       m_gie, m_ins;
  int       m_id;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_en[i] = 0; m_pend[i] = 0; m_prev[i] = 0;
    end
    m_gie = 0; m_ins = 0; m_id = 0;
  endfunction

  function automatic int model_winner();
    for (int i = 0; i < N; i++) if (m_pend[i] && m_en[i]) return i;
    return -1;
  endfunction

  function automatic bit model_intr(bit aj, bit rj, bit rt);
    return m_gie && !m_ins && (model_winner() >= 0) && !aj && !rj && !rt;
  endfunction

  function automatic int model_rdata(logic [1:0] a);
    int v = 0;
    case (a)
      2'd0: for (int i = 0; i < N; i++) v += m_en[i] * (1 << i);
      2'd1: for (int i = 0; i < N; i++) v += m_pend[i] * (1 << i);
      2'd2: v = m_gie + 2 * m_ins;
      default: v = m_id;
    endcase
    return v;
  endfunction

  task automatic model_clock(bit r, logic [N-1:0] irq, bit aj, bit rj, bit rt,
                             bit we, logic [1:0] a, logic [15:0] wd);
    bit fire;
    int w;
    if (r) begin
      model_reset();
      return;
    end
    fire = model_intr(aj, rj, rt);
    w = model_winner();
    if (fire) m_pend[w] = 0;
    for (int i = 0; i < N; i++) begin
      if (we && a == 2'd1 && wd[i]) m_pend[i] = 0;
      if (irq[i] && !m_prev[i]) m_pend[i] = 1;
      m_prev[i] = irq[i];
    end
    if (fire) begin
      m_ins = 1; m_id = w;
    end else if (rt) begin
      m_ins = 0;
    end
    if (we && a == 2'd0) for (int i = 0; i < N; i++) m_en[i] = wd[i];
    if (we && a == 2'd2) m_gie = wd[0];
  endtask

  // ---------------- checking ----------------
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic        s_intr, s_ins;
  logic [3:0]  s_id;
  logic [15:0] s_rdata;

  // One clock cycle: drive, sample mid-cycle against the model, clock, update.
  task automatic step(bit r, logic [N-1:0] irq, bit aj, bit rj, bit rt,
                      bit we, logic [1:0] a, logic [15:0] wd);
    rst = r; irq_in = irq; absJmp = aj; relJmp = rj; reti = rt;
    cfg_we = we; cfg_addr = a; cfg_wdata = wd;
    #4;
    s_intr = intr; s_ins = in_service; s_id = irq_id; s_rdata = cfg_rdata;
    chk("model_intr", int'(s_intr), int'(model_intr(aj, rj, rt)));
    chk("model_in_service", int'(s_ins), int'(m_ins));
    chk("model_irq_id", int'(s_id), m_id);
    chk("model_rdata", int'(s_rdata), model_rdata(a));
    @(posedge clk);
    model_clock(r, irq, aj, rj, rt, we, a, wd);
    #1;
  endtask

  task automatic idle(logic [N-1:0] irq, logic [1:0] a);
    step(0, irq, 0, 0, 0, 0, a, 16'h0);
  endtask

  task automatic wr(logic [1:0] a, logic [15:0] d);
    step(0, '0, 0, 0, 0, 1, a, d);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0] irq;
    logic         aj, rj, rt, we;
    logic [1:0]   a;
    logic [15:0]  wd;
    logic         e_intr, e_ins;
    logic [3:0]   e_id;
    logic [15:0]  e_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [N-1:0] irq, bit rt, bit we, logic [1:0] a,
                              logic [15:0] wd, bit ei, bit es, int eid, int erd);
    vec_t v;
    v.irq = irq; v.aj = 0; v.rj = 0; v.rt = rt; v.we = we; v.a = a; v.wd = wd;
    v.e_intr = ei; v.e_ins = es; v.e_id = 4'(eid); v.e_rdata = 16'(erd);
    return v;
  endfunction

  task automatic jump_case(int kind, string name);
    idle(4'b0001, 2'd1);
    for (int c = 0; c < 2; c++) begin
      step(0, '0, kind == 0, kind == 1, kind == 2, 0, 2'd1, 16'h0);
      chk({name, "_suppress"}, int'(s_intr), 0);
    end
    idle('0, 2'd1);
    chk({name, "_release"}, int'(s_intr), 1);
    idle('0, 2'd3);
    chk({name, "_id"}, int'(s_id), 0);
    step(0, '0, 0, 0, 1, 0, 2'd2, 16'h0);
    idle('0, 2'd2);
  endtask

  initial begin
    rst = 1; irq_in = '0; absJmp = 0; relJmp = 0; reti = 0;
    cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
    model_reset();
    @(posedge clk); #1;
    for (int a = 0; a < 4; a++) begin
      idle('0, 2'(a));
      chk("reset_reg", int'(s_rdata), 0);
    end
    chk("reset_intr", int'(s_intr), 0);

    // basic take, then priority 1-before-3 with reti handoff
    vecs.push_back(mk(4'h0, 0, 1, 2'd0, 16'h0001, 0, 0, 0, 16'h0));
    vecs.push_back(mk(4'h0, 0, 1, 2'd2, 16'h0001, 0, 0, 0, 16'h0));
    vecs.push_back(mk(4'h1, 0, 0, 2'd1, 16'h0,    0, 0, 0, 16'h0));
    vecs.push_back(mk(4'h1, 0, 0, 2'd1, 16'h0,    1, 0, 0, 16'h1));
    vecs.push_back(mk(4'h0, 0, 0, 2'd2, 16'h0,    0, 1, 0, 16'h3));
    vecs.push_back(mk(4'h0, 0, 0, 2'd1, 16'h0,    0, 1, 0, 16'h0));
    vecs.push_back(mk(4'h0, 1, 0, 2'd3, 16'h0,    0, 1, 0, 16'h0));
    vecs.push_back(mk(4'h0, 0, 0, 2'd2, 16'h0,    0, 0, 0, 16'h1));
    vecs.push_back(mk(4'h0, 0, 1, 2'd0, 16'h000F, 0, 0, 0, 16'h1));
    vecs.push_back(mk(4'hA, 0, 0, 2'd1, 16'h0,    0, 0, 0, 16'h0));
    vecs.push_back(mk(4'hA, 0, 0, 2'd1, 16'h0,    1, 0, 0, 16'hA));
    vecs.push_back(mk(4'h0, 0, 0, 2'd1, 16'h0,    0, 1, 1, 16'h8));
    vecs.push_back(mk(4'h0, 1, 0, 2'd3, 16'h0,    0, 1, 1, 16'h1));
    vecs.push_back(mk(4'h0, 0, 0, 2'd1, 16'h0,    1, 0, 1, 16'h8));
    vecs.push_back(mk(4'h0, 0, 0, 2'd1, 16'h0,    0, 1, 3, 16'h0));
    vecs.push_back(mk(4'h0, 1, 0, 2'd3, 16'h0,    0, 1, 3, 16'h3));
    vecs.push_back(mk(4'h0, 0, 0, 2'd2, 16'h0,    0, 0, 3, 16'h1));
    foreach (vecs[i]) begin
      step(0, vecs[i].irq, vecs[i].aj, vecs[i].rj, vecs[i].rt, vecs[i].we,
           vecs[i].a, vecs[i].wd);
      chk($sformatf("vec%0d_intr", i), int'(s_intr), int'(vecs[i].e_intr));
      chk($sformatf("vec%0d_in_service", i), int'(s_ins), int'(vecs[i].e_ins));
      chk($sformatf("vec%0d_irq_id", i), int'(s_id), int'(vecs[i].e_id));
      chk($sformatf("vec%0d_rdata", i), int'(s_rdata), int'(vecs[i].e_rdata));
    end

    jump_case(0, "absjmp");
    jump_case(1, "reljmp");
    jump_case(2, "reti_idle");

    // masking and W1C
    wr(2'd0, 16'h0);
    idle(4'h4, 2'd1);
    for (int c = 0; c < 3; c++) begin
      idle('0, 2'd1);
      chk("masked_pending", int'(s_rdata), 4);
      chk("masked_no_intr", int'(s_intr), 0);
    end
    wr(2'd1, 16'h0004);
    idle('0, 2'd1);
    chk("w1c_cleared", int'(s_rdata), 0);
    idle(4'h4, 2'd1);
    wr(2'd0, 16'h0004);
    chk("unmask_write_cycle", int'(s_intr), 0);
    idle('0, 2'd1);
    chk("unmask_fire", int'(s_intr), 1);
    step(0, '0, 0, 0, 1, 0, 2'd2, 16'h0);
    wr(2'd0, 16'h000F);

    // no nesting
    idle(4'h2, 2'd1);
    idle('0, 2'd1);
    chk("nest_first_take", int'(s_intr), 1);
    idle(4'h1, 2'd1);
    for (int c = 0; c < 3; c++) begin
      idle('0, 2'd1);
      chk("nest_pending", int'(s_rdata), 1);
      chk("nest_blocked", int'(s_intr), 0);
    end
    step(0, '0, 0, 0, 1, 0, 2'd1, 16'h0);
    chk("nest_reti_cycle", int'(s_intr), 0);
    idle('0, 2'd1);
    chk("nest_after_reti", int'(s_intr), 1);
    idle('0, 2'd3);
    chk("nest_id", int'(s_rdata), 0);
    step(0, '0, 0, 0, 1, 0, 2'd2, 16'h0);

    // reset mid-service with a line held high across reset
    idle(4'h3, 2'd1);
    idle('0, 2'd1);
    idle('0, 2'd1);
    chk("mid_pending", int'(s_rdata), 2);
    chk("mid_in_service", int'(s_ins), 1);
    step(1, 4'h8, 0, 0, 0, 0, 2'd1, 16'h0);
    idle(4'h8, 2'd1);
    chk("post_rst_pending", int'(s_rdata), 0);
    chk("post_rst_intr", int'(s_intr), 0);
    chk("post_rst_in_service", int'(s_ins), 0);
    chk("post_rst_irq_id", int'(s_id), 0);
    idle(4'h8, 2'd0);
    chk("post_rst_enable", int'(s_rdata), 0);
    idle(4'h8, 2'd2);
    chk("post_rst_ctrl", int'(s_rdata), 0);
    idle(4'h8, 2'd1);
    chk("held_line_pending", int'(s_rdata), 8);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bit          r, aj, rj, rt, we;
      logic [1:0]  a;
      logic [15:0] wd;
      r  = ($urandom_range(0, 299) == 0);
      aj = ($urandom_range(0, 7) == 0);
      rj = ($urandom_range(0, 7) == 0);
      rt = ($urandom_range(0, 5) == 0);
      we = ($urandom_range(0, 7) == 0);
      a  = 2'($urandom_range(0, 3));
      wd = 16'($urandom);
      if (we && a == 2'd2) wd[0] = ($urandom_range(0, 3) != 0);
      step(r, N'($urandom), aj, rj, rt, we, a, wd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Sits directly upstream of the program counter. It produces the program counter's `intr` request and tracks the `reti` return.
- Edge-detects up to 16 external IRQ lines and latches them as pending. Masks them with an enable register and a global enable.
- Arbitrates by fixed priority, where the lowest index wins, and issues a one-cycle `intr` only when the PC will accept it.
- Blocks nesting until `reti`. A small 16-bit config/status register file is exposed to the CPU data bus.

Parameters:
- NUM_IRQ, 4, number of IRQ inputs (1..16).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- irq_in  input  NUM_IRQ  external interrupt lines, already synchronous to clk; rising edge = request.
- absJmp  input  1  absolute jump being applied to the PC this cycle.
- relJmp  input  1  relative jump being applied to the PC this cycle.
- reti  input  1  return-from-interrupt decoded this cycle; same signal that drives the PC.
- cfg_we  input  1  register write strobe.
- cfg_addr  input  2  register select: 0 ENABLE, 1 PENDING, 2 CTRL, 3 CAUSE.
- cfg_wdata  input  16  write data.
- cfg_rdata  output  16  read data, combinational from cfg_addr.
- intr  output  1  interrupt request to the PC; one-cycle pulse.
- in_service  output  1  handler active (set on take, cleared by reti).
- irq_id  output  4  index of the source last taken.

Behaviour:
- Reset (rst=1 at posedge) clears: enable=0, pending=0, gie=0, in_service=0, irq_id=0, irq_prev=0.
  - Because irq_prev resets to 0, a line held high through reset registers as an edge on the first cycle after reset.
- Edge detect, each posedge:
  - irq_prev <= irq_in.
  - pending[i] is set when irq_in[i]=1 and irq_prev[i]=0. Edge-to-pending latency is 1 clock.
- Request, combinational: req = pending & enable; sel = lowest set index of req.
- intr = gie & ~in_service & (|req) & ~absJmp & ~relJmp & ~reti.
  - Jumps and reti suppress intr because the PC gives jumps priority and would otherwise lose the saved return address.
- Take, at a posedge with intr=1:
  - in_service <= 1.
  - irq_id <= sel.
  - pending[sel] <= 0.
  - Since in_service is now set, intr is exactly one cycle wide.
- Return, at a posedge with reti=1:
  - in_service <= 0. reti while in_service=0 is ignored.
  - The next intr can fire in the cycle after reti, if req is non-zero.
- Simultaneous events on pending[i] in one posedge:
  - A new edge wins over any clear: clear by take or W1C together with a new edge leaves the bit set.
  - A W1C on the bit being taken is harmless; the bit ends cleared.
- Registers (writes at posedge when cfg_we=1):
  - 0 ENABLE: R/W, bits [NUM_IRQ-1:0]; upper bits read 0.
  - 1 PENDING: read returns pending; write-1-to-clear; writing 0 has no effect.
  - 2 CTRL: bit0 gie R/W; bit1 in_service read-only; other bits read 0.
  - 3 CAUSE: read-only, {12'b0, irq_id}; writes ignored.
- Clearing gie or enable does not affect an in-service handler. Pending bits stay latched while masked and fire once unmasked.
- Reset mid-handler clears in_service; the PC is reset in the same cycle, so no reti is expected.

Decomposition:
- Shared package holds:
  - register address constants: REG_ENABLE=0, REG_PENDING=1, REG_CTRL=2, REG_CAUSE=3;
  - CTRL bit positions: CTRL_GIE=0, CTRL_INSERV=1;
  - IRQ_ID_W=4 and MAX_IRQ=16.
- One sub-module: irq_priority_encoder. Combinational; req[NUM_IRQ-1:0] to {valid, index}, lowest index wins.

Test Plan:
- Basic take:
  - Stimulus: reset; write ENABLE=0x1, CTRL=0x1; pulse irq_in[0] at cycle 10.
  - Required: pending[0]=1 at cycle 11; intr=1 for exactly cycle 11; in_service=1 and irq_id=0 from cycle 12; pending=0.
- Priority:
  - Stimulus: enable=0xF, gie=1; raise irq_in[3] and irq_in[1] in the same cycle.
  - Required: first take irq_id=1 with pending=0x8; reti; the next cycle intr fires again, irq_id=3, pending=0.
- Jump suppression:
  - Stimulus: pending and enabled with absJmp=1 for cycles 20–21.
  - Required: intr=0 in cycles 20–21 and =1 in cycle 22. Same check with relJmp and with reti while not in service.
- Masking and W1C:
  - Stimulus: edge on irq_in[2] with enable=0.
  - Required: pending=0x4, intr never asserts; write PENDING=0x4 clears it. Repeat the edge, then set enable=0x4: intr fires in the cycle after the write.
- No nesting:
  - Stimulus: during in_service=1, an edge on irq_in[0].
  - Required: pending[0] sets but intr stays 0 until the cycle after reti, then irq_id=0.
- Reset mid-service:
  - Stimulus: rst=1 for one cycle while in_service=1 and pending=0x2.
  - Required: all registers are 0 next cycle and intr=0. If irq_in is held high across reset, pending sets 1 cycle after rst drops.
